uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter, directly downstream of the MMIO interface block.
- Consumes the one-cycle tx_en strobe and tx_data byte that the MMIO interface produces on a UART data write.
- Queues bytes in a small FIFO and serialises them onto txd as 8N1 frames, LSB first.
- Returns busy/full/count/overflow status for the MMIO read path.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_HZ/BAUD (integer division, must be at least 2) clocks per bit.
- DEPTH, 16, FIFO entries; power of two, at least 2. AW = log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_en  in  1  single-cycle push strobe from the MMIO interface.
- tx_data  in  8  byte to push, sampled when tx_en=1.
- clr_ovf  in  1  single-cycle strobe; clears the overflow flag.
- txd  out  1  serial output; idles high.
- tx_busy  out  1  1 when the FSM is not IDLE or the FIFO is non-empty.
- fifo_full  out  1  count == DEPTH.
- fifo_count  out  AW+1  number of queued bytes, excluding the byte currently being shifted.
- overflow  out  1  sticky flag; set when a push is dropped.
- tx_done  out  1  one-cycle pulse on the last clock of each stop bit.

Behaviour:
- Reset (rst=0, async): FIFO pointers and count cleared; FSM to IDLE.
  - Output reset values: txd=1, tx_busy=0, fifo_full=0, fifo_count=0, overflow=0, tx_done=0.
  - FIFO storage is not reset.
  - Reset asserted mid-frame aborts the frame immediately; txd returns to 1 asynchronously.
- Push: on an edge with tx_en=1 and count<DEPTH, write tx_data at wr_ptr and advance wr_ptr (wraps mod DEPTH).
- Push when full is determined by the count at the start of the cycle:
  - The byte is dropped and overflow <= 1.
  - This holds even if a pop occurs in the same cycle.
- overflow: clr_ovf clears it. If clr_ovf and a dropped push occur in the same cycle, set wins.
- Pop: the FSM pops (reads rd_ptr, advances it) when entering START. count <= count + push_accepted - pop.
- FSM states: IDLE, START, DATA, STOP. baud_cnt counts DIV-1 down to 0; bit_idx is 0..7.
  - IDLE: txd=1. If count>0 at an edge, pop into shift register, go to START, load baud_cnt=DIV-1.
  - START: txd=0 for DIV clocks. At baud_cnt=0 go to DATA with bit_idx=0.
  - DATA: txd=shift[0] for DIV clocks per bit. At baud_cnt=0, shift right and increment bit_idx. After bit 7 go to STOP.
  - STOP: txd=1 for DIV clocks. tx_done=1 on the cycle where baud_cnt=0.
    - Then if count>0, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Latency with empty FIFO and IDLE FSM:
  - Edge E0 samples tx_en; the FIFO write is visible after E0.
  - Edge E1 pops and enters START; txd falls after E1.
  - Frame length is exactly 10*DIV clocks.
- A push to an empty FIFO while the FSM is in STOP is accepted and sent back-to-back.
- The FIFO never reads and writes the same slot in one cycle when count is 0: the pop is gated by the registered count, so a same-cycle push is not bypassed.
- txd is registered (glitch-free) and driven from the state/shift registers.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/STOP);
  - function computing DIV from CLK_HZ/BAUD;
  - frame constants (DATA_BITS=8, STOP_BITS=1).
- One sub-module: sync_fifo, parameterised on width and DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Async active-low reset on pointers only.
- The FSM and baud counter stay in uart_tx_fifo.

Test Plan (CLK_HZ=1000000, BAUD=100000, so DIV=10; DEPTH=4):
- Single byte: tx_en with 0xA5 -> txd low 1 clk later for 10 clks, then bits 1,0,1,0,0,1,0,1 at 10 clks each, then high; tx_done pulse at clk 100 of the frame; tx_busy drops the cycle after.
- Burst: push 0x01,0x02,0x03 on consecutive cycles -> fifo_count peaks at 2; three frames back-to-back, 300 clks, no idle high between stop and the next start.
- Overflow: push 6 bytes in consecutive cycles -> bytes 1-5 accepted (one popped by the FSM, 4 queued), byte 6 dropped, overflow=1; clr_ovf -> overflow=0; clr_ovf together with a dropped push -> overflow stays 1.
- Full plus pop boundary: FIFO full while STOP finishes and tx_en arrives in the pop cycle -> push dropped, count goes 4->3, overflow=1.
- Reset mid-frame: rst=0 during DATA bit 3 -> txd=1 immediately with no clock; count=0; after release, a new byte 0x3C is transmitted correctly.
- Idle line: no pushes for 500 clks -> txd=1, tx_busy=0, tx_done never pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, frame constants and baud divisor helper for the UART transmitter
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational read port; pointers reset, storage does not
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count, so a push into an empty FIFO is never bypassed to dout
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter: byte FIFO feeding a registered-output serialiser
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_en,
  input  logic [7:0]               tx_data,
  input  logic                     clr_ovf,
  output logic                     txd,
  output logic                     tx_busy,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     tx_done
);

  localparam int DIV      = calc_div(CLK_HZ, BAUD);
  localparam int STOP_LEN = DIV * STOP_BITS;
  localparam int CW       = $clog2(STOP_LEN);
  localparam int BW       = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 overflow_q, overflow_d;

  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (tx_en),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = BIT_LAST;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          baud_d    = BIT_LAST;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IDX_LAST) begin
            baud_d  = STOP_LAST;
            state_d = ST_STOP;
          end else begin
            baud_d    = BIT_LAST;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          // Chain straight into the next start bit so queued bytes leave with no idle gap
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            baud_d   = BIT_LAST;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is a function of where the FSM will be, so txd can be a plain flop
    txd_d = 1'b1;
    if (state_d == ST_START) begin
      txd_d = 1'b0;
    end else if (state_d == ST_DATA) begin
      txd_d = shift_d[0];
    end

    overflow_d = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (tx_en && fifo_full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

  assign txd      = txd_q;
  assign overflow = overflow_q;
  assign tx_busy  = (state_q != ST_IDLE) || !fifo_empty;
  assign tx_done  = (state_q == ST_STOP) && (baud_q == '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench: frame-level reference model plus directed literal checks
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DEPTH  = 4;
  localparam int DIV    = 10;
  localparam int FRAME  = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       txd;
  logic       tx_busy;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       tx_done;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Frame-level reference: a byte queue and a position within the current 10*DIV-clock frame
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  bit         m_ovf = 1'b0;
  logic [7:0] m_byte = 8'h00;

  uart_tx_fifo #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .clr_ovf    (clr_ovf),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_txd();
    if (!m_active) return 1;
    if (m_pos < DIV) return 0;
    if (m_pos < 9 * DIV) return int'(m_byte[(m_pos - DIV) / DIV]);
    return 1;
  endfunction

  initial begin
    forever begin
      int n0;
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        m_active = 1'b0;
        m_pos    = 0;
        m_ovf    = 1'b0;
      end else begin
        n0 = mq.size();
        if (m_active) begin
          m_pos++;
          if (m_pos == FRAME) begin
            if (n0 > 0) begin
              m_byte = mq.pop_front();
              m_pos  = 0;
            end else begin
              m_active = 1'b0;
            end
          end
        end else if (n0 > 0) begin
          m_byte   = mq.pop_front();
          m_active = 1'b1;
          m_pos    = 0;
        end
        if (clr_ovf) m_ovf = 1'b0;
        if (tx_en) begin
          if (n0 < DEPTH) mq.push_back(tx_data);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_txd", int'(txd), exp_txd());
        chk("m_busy", int'(tx_busy), int'(m_active || mq.size() > 0));
        chk("m_count", int'(fifo_count), mq.size());
        chk("m_full", int'(fifo_full), int'(mq.size() == DEPTH));
        chk("m_ovf", int'(overflow), int'(m_ovf));
        chk("m_done", int'(tx_done), int'(m_active && m_pos == FRAME - 1));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // pat[i] is the line level during frame bit i: start, d0..d7, stop
  task automatic send_check(input logic [7:0] d, input logic [9:0] pat, input string tag);
    int t_done;
    int t_idle;
    tx_en = 1'b1;
    tx_data = d;
    tick(1);
    tx_en = 1'b0;
    chk({tag, "_cnt1"}, int'(fifo_count), 1);
    tick(1);
    t_done = -1;
    t_idle = -1;
    for (int t = 0; t < 110; t++) begin
      if (t % 10 == 5 && t < 100) chk({tag, "_bit"}, int'(txd), int'(pat[t / 10]));
      if (tx_done && t_done < 0) t_done = t;
      if (!tx_busy && t_idle < 0) t_idle = t;
      tick(1);
    end
    chk({tag, "_done_pos"}, t_done, 99);
    chk({tag, "_idle_pos"}, t_idle, 100);
  endtask

  initial begin
    int busy_n;
    int done_n;
    int maxc;
    int low_n;
    int w;

    #1 rst = 1'b0;
    #1;
    chk("rst_txd", int'(txd), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_done", int'(tx_done), 0);
    tick(3);
    rst = 1'b1;
    cmp_en = 1'b1;
    tick(2);

    send_check(8'hA5, 10'b1_10100101_0, "a5");

    busy_n = 0;
    done_n = 0;
    maxc = 0;
    tx_en = 1'b1;
    tx_data = 8'h01;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      busy_n += int'(tx_busy);
      done_n += int'(tx_done);
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (c == 0) tx_data = 8'h02;
      if (c == 1) tx_data = 8'h03;
      if (c == 2) tx_en = 1'b0;
    end
    chk("burst_peak", maxc, 2);
    chk("burst_busy", busy_n, 301);
    chk("burst_done", done_n, 3);

    tx_en = 1'b1;
    tx_data = 8'h10;
    for (int i = 1; i < 6; i++) begin
      tick(1);
      tx_data = 8'h10 + 8'(i);
    end
    tick(1);
    tx_en = 1'b0;
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(fifo_count), 4);
    chk("ovf_full", int'(fifo_full), 1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("ovf_clr", int'(overflow), 0);
    clr_ovf = 1'b1;
    tx_en = 1'b1;
    tx_data = 8'h77;
    tick(1);
    clr_ovf = 1'b0;
    tx_en = 1'b0;
    chk("ovf_set_wins", int'(overflow), 1);
    chk("ovf_count2", int'(fifo_count), 4);
    tick(520);
    chk("ovf_drained", int'(tx_busy), 0);

    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    tx_en = 1'b1;
    tx_data = 8'h21;
    for (int i = 1; i < 5; i++) begin
      tick(1);
      tx_data = 8'h21 + 8'(i);
    end
    tick(1);
    tx_en = 1'b0;
    chk("bnd_full", int'(fifo_full), 1);
    w = 0;
    while (!tx_done && w < 200) begin
      tick(1);
      w++;
    end
    chk("bnd_wait_done", int'(tx_done), 1);
    chk("bnd_count4", int'(fifo_count), 4);
    tx_en = 1'b1;
    tx_data = 8'h99;
    tick(1);
    tx_en = 1'b0;
    chk("bnd_count3", int'(fifo_count), 3);
    chk("bnd_ovf", int'(overflow), 1);
    chk("bnd_notfull", int'(fifo_full), 0);
    tick(420);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    tick(2);

    tx_en = 1'b1;
    tx_data = 8'h00;
    tick(1);
    tx_data = 8'h55;
    tick(1);
    tx_en = 1'b0;
    tick(45);
    chk("mid_txd_low", int'(txd), 0);
    chk("mid_count", int'(fifo_count), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_txd", int'(txd), 1);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_busy", int'(tx_busy), 0);
    tick(3);
    rst = 1'b1;
    tick(2);
    send_check(8'h3C, 10'b1_00111100_0, "b3c");

    busy_n = 0;
    done_n = 0;
    low_n = 0;
    for (int c = 0; c < 500; c++) begin
      tick(1);
      busy_n += int'(tx_busy);
      done_n += int'(tx_done);
      low_n  += int'(!txd);
    end
    chk("idle_busy", busy_n, 0);
    chk("idle_done", done_n, 0);
    chk("idle_txd_low", low_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
